// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: instruction-fetch port, data port and SRAM port.
// The master modport is the requester/SRAM side and the slave modport is the arbiter side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    localparam int STRB_W = DATA_W / 8;

    // Instruction-fetch requester
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_cancel;

    // Data (load/store) requester
    logic              data_req;
    logic              data_wr;
    logic [ADDR_W-1:0] data_addr;
    logic [STRB_W-1:0] data_wstrb;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    // Single-port synchronous SRAM
    logic              sram_en;
    logic [STRB_W-1:0] sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport master (
        output inst_req, inst_addr, inst_cancel,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );

    modport slave (
        input  inst_req, inst_addr, inst_cancel,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM between the fetch and
// data requesters. At most one grant per cycle, fixed one-cycle read latency,
// fully pipelined. inst_cancel drops the fetch response returning this cycle and
// blocks a fetch grant this cycle.
// Optional feature: define ARB_RR_EN to alternate grants under contention
// (round-robin on last_grant); otherwise data always wins over fetch.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    // Arbitration
    logic              elig_i;
    logic              elig_d;
    logic              grant_i;
    logic              grant_d;

    // SRAM drive (combinational, valid in the grant cycle)
    logic              sram_en_c;
    logic [STRB_W-1:0] sram_we_c;
    logic [ADDR_W-1:0] sram_addr_c;
    logic [DATA_W-1:0] sram_wdata_c;

    // Response tracking: which requester owns the SRAM read data next cycle
    logic              resp_v_d;
    logic              resp_v_q;
    owner_e            resp_owner_d;
    owner_e            resp_owner_q;

    // Response strobes
    logic              inst_data_ok_c;
    logic              data_data_ok_c;

`ifdef ARB_RR_EN
    owner_e            last_grant_d;
    owner_e            last_grant_q;
`endif

    // Decide who (if anyone) gets the SRAM this cycle; nothing is granted in reset.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        grant_i = 1'b0;
        grant_d = 1'b0;
        elig_i  = bus.inst_req & ~bus.inst_cancel & ~rst;
        elig_d  = bus.data_req & ~rst;
`ifdef ARB_RR_EN
        if (elig_i && elig_d) begin
            // Contention: hand the port to whoever did not get it last time.
            grant_d = (last_grant_q == OWNER_INST);
            grant_i = (last_grant_q == OWNER_DATA);
        end else begin
            grant_d = elig_d;
            grant_i = elig_i;
        end
`else
        grant_d = elig_d;
        grant_i = elig_i & ~elig_d;
`endif
    end

    // Steer the granted requester onto the SRAM port; all-zero when idle.
    always_comb begin
        sram_en_c    = 1'b0;
        sram_we_c    = '0;
        sram_addr_c  = '0;
        sram_wdata_c = '0;
        if (grant_d) begin
            sram_en_c    = 1'b1;
            sram_we_c    = bus.data_wr ? bus.data_wstrb : '0;
            sram_addr_c  = bus.data_addr;
            sram_wdata_c = bus.data_wdata;
        end else if (grant_i) begin
            sram_en_c    = 1'b1;
            sram_addr_c  = bus.inst_addr;
        end
    end

    // Next-state for the response tracker (and last_grant when round-robin is built).
    always_comb begin
        resp_v_d     = grant_i | grant_d;
        resp_owner_d = grant_d ? OWNER_DATA : OWNER_INST;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
        if (grant_d) begin
            last_grant_d = OWNER_DATA;
        end else if (grant_i) begin
            last_grant_d = OWNER_INST;
        end
`endif
    end

    // Response tracker registers; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples the
        // pre-edge value of its _d, independent of statement order; reset is
        // synchronous, so it is only seen at the clock edge.
        if (rst) begin
            resp_v_q     <= 1'b0;
            resp_owner_q <= OWNER_INST;
        end else begin
            resp_v_q     <= resp_v_d;
            resp_owner_q <= resp_owner_d;
        end
    end

`ifdef ARB_RR_EN
    // Remember the most recent winner; INST after reset so data wins first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWNER_INST;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Response strobes one cycle after the grant; a fetch response is dropped on cancel.
    always_comb begin
        inst_data_ok_c = resp_v_q & (resp_owner_q == OWNER_INST) & ~bus.inst_cancel & ~rst;
        data_data_ok_c = resp_v_q & (resp_owner_q == OWNER_DATA) & ~rst;
    end

    assign bus.inst_addr_ok = grant_i;
    assign bus.data_addr_ok = grant_d;
    assign bus.inst_data_ok = inst_data_ok_c;
    assign bus.data_data_ok = data_data_ok_c;

    // Read data is shared; each copy is qualified by its own data_ok.
    assign bus.inst_rdata   = bus.sram_rdata;
    assign bus.data_rdata   = bus.sram_rdata;

    assign bus.sram_en      = sram_en_c;
    assign bus.sram_we      = sram_we_c;
    assign bus.sram_addr    = sram_addr_c;
    assign bus.sram_wdata   = sram_wdata_c;

    // Structural sanity: one grant at most, and a cancelled fetch is never granted.
    a_single_grant : assert property (@(posedge clk) !(grant_i && grant_d));
    a_cancel_block : assert property (@(posedge clk) bus.inst_cancel |-> !grant_i);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural SRAM, a reference memory,
// and per-requester response queues filled when stimulus is driven and drained
// when responses are due. Honours ARB_RR_EN when the RTL is built with it.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        icancel;
        logic        dreq;
        logic        dwr;
        logic [31:0] daddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } stim_t;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        chk_data;
    } resp_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    mon_en   = 0;
    bit    last_was_data = 0;

    resp_t iq[$];
    resp_t dq[$];
    resp_t m_e;
    logic  m_ok;

    logic        exp_i_aok, exp_d_aok, exp_en;
    logic [3:0]  exp_we;
    logic [31:0] exp_addr, exp_wdata;

    logic [31:0] sram_mem [512];
    bit          sram_flag[512];
    logic [31:0] ref_mem  [512];
    bit          ref_flag [512];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    function automatic int unsigned idx(input logic [31:0] a);
        return {23'd0, a[28], a[9:2]};
    endfunction

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == idx(32'h1c00_0000)) return 32'h0280_0c0c;
        if (i == idx(32'h0000_0200)) return 32'h1122_3344;
        return 32'hc0de_0000 | i;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] sram_word(input int unsigned i);
        return sram_flag[i] ? sram_mem[i] : init_word(i);
    endfunction

    function automatic logic [31:0] ref_word(input int unsigned i);
        return ref_flag[i] ? ref_mem[i] : init_word(i);
    endfunction

    // Behavioural SRAM: read data registered, valid the cycle after sram_en.
    always @(posedge clk) begin
        if (bus.sram_en) begin
            bus.sram_rdata <= sram_word(idx(bus.sram_addr));
            if (|bus.sram_we) begin
                sram_mem[idx(bus.sram_addr)]  <= merge(sram_word(idx(bus.sram_addr)),
                                                       bus.sram_wdata, bus.sram_we);
                sram_flag[idx(bus.sram_addr)] <= 1'b1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.ireq = 0; s.iaddr = '0; s.icancel = 0;
        s.dreq = 0; s.dwr = 0; s.daddr = '0; s.wstrb = '0; s.wdata = '0;
        return s;
    endfunction

    // Apply one cycle of stimulus and predict grant, SRAM drive and responses.
    task automatic drive(input stim_t s);
        logic  ei, ed, gi, gd;
        resp_t e;
        @(posedge clk);
        #1;
        rst             = s.rst;
        bus.inst_req    = s.ireq;
        bus.inst_addr   = s.iaddr;
        bus.inst_cancel = s.icancel;
        bus.data_req    = s.dreq;
        bus.data_wr     = s.dwr;
        bus.data_addr   = s.daddr;
        bus.data_wstrb  = s.wstrb;
        bus.data_wdata  = s.wdata;

        ei = s.ireq & ~s.icancel & ~s.rst;
        ed = s.dreq & ~s.rst;
`ifdef ARB_RR_EN
        if (ei && ed) begin
            gd = !last_was_data;
            gi = last_was_data;
        end else begin
            gd = ed;
            gi = ei;
        end
        if (s.rst) last_was_data = 0;
        else if (gd) last_was_data = 1;
        else if (gi) last_was_data = 0;
`else
        gd = ed;
        gi = ei & ~ed;
`endif
        exp_i_aok = gi;
        exp_d_aok = gd;
        exp_en    = gi | gd;
        exp_we    = (gd && s.dwr) ? s.wstrb : 4'h0;
        exp_addr  = gd ? s.daddr : (gi ? s.iaddr : 32'h0);
        exp_wdata = gd ? s.wdata : 32'h0;

        if (gi) begin
            e.due = cyc + 1; e.data = ref_word(idx(s.iaddr)); e.chk_data = 1;
            iq.push_back(e);
        end
        if (gd) begin
            e.due = cyc + 1; e.data = ref_word(idx(s.daddr)); e.chk_data = !s.dwr;
            dq.push_back(e);
            if (s.dwr) begin
                ref_mem[idx(s.daddr)]  = merge(ref_word(idx(s.daddr)), s.wdata, s.wstrb);
                ref_flag[idx(s.daddr)] = 1;
            end
        end
        mon_en = 1;
    endtask

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("inst_addr_ok", {31'd0, bus.inst_addr_ok}, {31'd0, exp_i_aok});
            check("data_addr_ok", {31'd0, bus.data_addr_ok}, {31'd0, exp_d_aok});
            check("sram_en",      {31'd0, bus.sram_en},      {31'd0, exp_en});
            check("sram_we",      {28'd0, bus.sram_we},      {28'd0, exp_we});
            check("sram_addr",    bus.sram_addr,             exp_addr);
            check("sram_wdata",   bus.sram_wdata,            exp_wdata);

            if (iq.size() > 0 && iq[0].due == cyc) begin
                m_e  = iq.pop_front();
                m_ok = !rst && !bus.inst_cancel;
                check("inst_data_ok", {31'd0, bus.inst_data_ok}, {31'd0, m_ok});
                if (m_ok && m_e.chk_data) check("inst_rdata", bus.inst_rdata, m_e.data);
            end else begin
                check("inst_data_ok_idle", {31'd0, bus.inst_data_ok}, 32'd0);
            end

            if (dq.size() > 0 && dq[0].due == cyc) begin
                m_e  = dq.pop_front();
                m_ok = !rst;
                check("data_data_ok", {31'd0, bus.data_data_ok}, {31'd0, m_ok});
                if (m_ok && m_e.chk_data) check("data_rdata", bus.data_rdata, m_e.data);
            end else begin
                check("data_data_ok_idle", {31'd0, bus.data_data_ok}, 32'd0);
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        bus.inst_req = 0; bus.inst_addr = '0; bus.inst_cancel = 0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_addr = '0;
        bus.data_wstrb = '0; bus.data_wdata = '0;

        // Reset with requests asserted: everything must stay quiet.
        s = idle(); s.rst = 1; s.ireq = 1; s.dreq = 1; s.dwr = 1; s.wstrb = 4'hf;
        s.daddr = 32'h100; s.wdata = 32'h5555_aaaa;
        repeat (2) drive(s);
        drive(idle());

        // Single fetch.
        s = idle(); s.ireq = 1; s.iaddr = 32'h1c00_0000;
        drive(s);
        drive(idle());

        // Contention, then the held fetch gets through.
        s = idle(); s.ireq = 1; s.iaddr = 32'h1c00_0000; s.dreq = 1; s.daddr = 32'h100;
        drive(s);
        s.dreq = 0;
        drive(s);
        drive(idle());

        // Repeated contention (fixed: D,D,D,D; round-robin: D,I,D,I).
        s = idle(); s.ireq = 1; s.iaddr = 32'h4; s.dreq = 1; s.daddr = 32'h100;
        repeat (4) drive(s);
        s.dreq = 0;
        drive(s);
        drive(idle());

        // Partial write, then fetch and load of the same word.
        s = idle(); s.dreq = 1; s.dwr = 1; s.daddr = 32'h200; s.wstrb = 4'b0011;
        s.wdata = 32'hdead_beef;
        drive(s);
        s = idle(); s.ireq = 1; s.iaddr = 32'h200;
        drive(s);
        s = idle(); s.dreq = 1; s.daddr = 32'h200; s.wdata = 32'h1234_5678;
        drive(s);
        drive(idle());

        // Cancel: fetch at T, cancel at T+1 with a new fetch and a data load.
        s = idle(); s.ireq = 1; s.iaddr = 32'h0;
        drive(s);
        s = idle(); s.ireq = 1; s.iaddr = 32'h4; s.icancel = 1; s.dreq = 1; s.daddr = 32'h100;
        drive(s);
        // Cancel while a data response returns: data side unaffected.
        s = idle(); s.ireq = 1; s.iaddr = 32'h8; s.icancel = 1;
        drive(s);
        drive(idle());

        // Back-to-back fetches.
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.ireq = 1; s.iaddr = 32'(i * 4);
            drive(s);
        end
        drive(idle());

        // Reset mid-flight: the in-flight fetch response is discarded.
        s = idle(); s.ireq = 1; s.iaddr = 32'h8;
        drive(s);
        s.rst = 1; s.dreq = 1; s.daddr = 32'h200;
        repeat (2) drive(s);
        repeat (2) drive(idle());

        // Recovery after reset.
        s = idle(); s.dreq = 1; s.daddr = 32'h200;
        drive(s);
        s = idle(); s.ireq = 1; s.iaddr = 32'h1c00_0000;
        drive(s);
        repeat (2) drive(idle());

        @(posedge clk);
        #1;
        mon_en = 0;
        check("inst_queue_drained", iq.size(), 32'd0);
        check("data_queue_drained", dq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
